// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: access-size codes, FSM states and
// the wait-counter width.
package dm_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } dm_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dm_state_e;

endpackage

// File: rtl/dm_responder_if.sv
// Load/store port between the MEM stage (master) and the data-memory responder (slave).
interface dm_responder_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_lane_unit.sv
// Byte-lane steering: byte enables, replicated store data and extended load data.
// DM_ALIGN_CHECK_EN flags misaligned/reserved accesses instead of aligning them down.
module dm_lane_unit
  import dm_pkg::*;
(
  input  dm_size_e    size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    err_o   = 1'b0;
    off     = addr_i;
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
`ifdef DM_ALIGN_CHECK_EN
    unique case (size_i)
      SZ_HALF: err_o = addr_i[0];
      SZ_WORD: err_o = (addr_i != 2'b00);
      SZ_RSVD: err_o = 1'b1;
      default: err_o = 1'b0;
    endcase
`else
    unique case (size_i)
      SZ_BYTE: off = addr_i;
      SZ_HALF: off = {addr_i[1], 1'b0};
      default: off = 2'b00;
    endcase
`endif
    shifted = word_i >> {off, 3'b000};
    // Store data is replicated across lanes; byte enables pick the live lane(s).
    unique case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << off;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYCLES wait states,
// response held until consumed. Optional DM_ALIGN_CHECK_EN reports misaligned accesses.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  dm_responder_if.slave bus
);

  localparam int unsigned      WORDS     = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, signed_q;
  dm_size_e          size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              enter_resp;
  logic              mem_we;
  logic              cur_wr, cur_signed;
  dm_size_e          cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_rdata;
  logic              lane_err;

  logic [31:0] mem [WORDS];

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_wr     = bus.req_wr;
      cur_signed = bus.req_signed;
      cur_size   = dm_size_e'(bus.req_size);
      cur_addr   = bus.req_addr;
      cur_wdata  = bus.req_wdata;
    end else begin
      cur_wr     = wr_q;
      cur_signed = signed_q;
      cur_size   = size_q;
      cur_addr   = addr_q;
      cur_wdata  = wdata_q;
    end
  end

  dm_lane_unit u_lane (
    .size_i   (cur_size),
    .signed_i (cur_signed),
    .addr_i   (cur_addr[1:0]),
    .wdata_i  (cur_wdata),
    .word_i   (mem[cur_addr[ADDR_W-1:2]]),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata),
    .err_o    (lane_err)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cnt_d = WAIT_INIT;
          if (WAIT_CYCLES == 0) enter_resp = 1'b1;
          else                  state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) enter_resp = 1'b1;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_resp) begin
      state_d = ST_RESP;
      err_d   = lane_err;
      rdata_d = (cur_wr || lane_err) ? 32'h0 : lane_rdata;
    end
  end

  assign mem_we = enter_resp && cur_wr && !lane_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (state_q == ST_IDLE && bus.req_valid) begin
      wr_q     <= bus.req_wr;
      signed_q <= bus.req_signed;
      size_q   <= dm_size_e'(bus.req_size);
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end
  end

  // Array is not reset; rst still blocks a write on an aborting edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem[cur_addr[ADDR_W-1:2]][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (WAIT_CYCLES 2, 0, 3) share one
// request bus; sel routes req_valid to one instance and muxes its outputs back.
module tb_dm_responder;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  int          sel = 0;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int lat[3] = '{3, 1, 4};

  always #5 clk = ~clk;

  dm_responder_if #(.ADDR_W(12)) bus0 ();
  dm_responder_if #(.ADDR_W(12)) bus1 ();
  dm_responder_if #(.ADDR_W(12)) bus2 ();

  assign bus0.req_valid = req_valid && (sel == 0);
  assign bus1.req_valid = req_valid && (sel == 1);
  assign bus2.req_valid = req_valid && (sel == 2);
  assign bus0.req_wr = req_wr;         assign bus1.req_wr = req_wr;
  assign bus2.req_wr = req_wr;
  assign bus0.req_size = req_size;     assign bus1.req_size = req_size;
  assign bus2.req_size = req_size;
  assign bus0.req_signed = req_signed; assign bus1.req_signed = req_signed;
  assign bus2.req_signed = req_signed;
  assign bus0.req_addr = req_addr;     assign bus1.req_addr = req_addr;
  assign bus2.req_addr = req_addr;
  assign bus0.req_wdata = req_wdata;   assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;
  assign bus0.rsp_ready = rsp_ready;   assign bus1.rsp_ready = rsp_ready;
  assign bus2.rsp_ready = rsp_ready;

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always_comb begin
    m_req_ready = bus0.req_ready;
    m_rsp_valid = bus0.rsp_valid;
    m_rsp_rdata = bus0.rsp_rdata;
    m_rsp_err   = bus0.rsp_err;
    case (sel)
      1: begin
        m_req_ready = bus1.req_ready;
        m_rsp_valid = bus1.rsp_valid;
        m_rsp_rdata = bus1.rsp_rdata;
        m_rsp_err   = bus1.rsp_err;
      end
      2: begin
        m_req_ready = bus2.req_ready;
        m_rsp_valid = bus2.rsp_valid;
        m_rsp_rdata = bus2.rsp_rdata;
        m_rsp_err   = bus2.rsp_err;
      end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_req(input int s, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int n;
    @(negedge clk);
    sel = s; rsp_ready = 1'b1;
    req_wr = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    chk({nm, " req_ready"}, 32'(m_req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_rsp_valid && n < 40);
    chk({nm, " latency"}, n, lat[s]);
    chk({nm, " rdata"}, m_rsp_rdata, exp_rd);
    chk({nm, " err"}, 32'(m_rsp_err), 32'(exp_err));
    @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[20];
    logic [31:0] cap;
    int n;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 12'h010, 32'h12345678, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'h12345678, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 12'h020, 32'hAABBCCDD, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 12'h021, 32'h0000005A, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'hAABB5ADD, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 12'h023, 32'h0, 32'hFFFFFFAA, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 12'h023, 32'h0, 32'h000000AA, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 12'h022, 32'h0, 32'hFFFFAABB, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 12'h022, 32'h0, 32'h0000AABB, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 12'h021, 32'h0, 32'h0000005A, 1'b0};
    vecs[10] = '{1'b1, 2'b01, 1'b0, 12'h020, 32'hFFFF8001, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'hAABB8001, 1'b0};
    vecs[12] = '{1'b0, 2'b01, 1'b1, 12'h020, 32'h0, 32'hFFFF8001, 1'b0};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 12'h044, 32'h11111111, 32'h0, 1'b0};
`ifdef DM_ALIGN_CHECK_EN
    vecs[14] = '{1'b1, 2'b10, 1'b0, 12'h045, 32'h99887766, 32'h0, 1'b1};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 12'h044, 32'h0, 32'h11111111, 1'b0};
    vecs[16] = '{1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 32'h0, 1'b1};
    vecs[17] = '{1'b0, 2'b01, 1'b1, 12'h023, 32'h0, 32'h0, 1'b1};
    vecs[18] = '{1'b1, 2'b00, 1'b0, 12'h047, 32'h123456EE, 32'h0, 1'b0};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 12'h044, 32'h0, 32'hEE111111, 1'b0};
`else
    vecs[14] = '{1'b1, 2'b10, 1'b0, 12'h045, 32'h99887766, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 12'h044, 32'h0, 32'h99887766, 1'b0};
    vecs[16] = '{1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 32'h12345678, 1'b0};
    vecs[17] = '{1'b0, 2'b01, 1'b1, 12'h023, 32'h0, 32'hFFFFAABB, 1'b0};
    vecs[18] = '{1'b1, 2'b00, 1'b0, 12'h047, 32'h123456EE, 32'h0, 1'b0};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 12'h044, 32'h0, 32'hEE887766, 1'b0};
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 32'(m_req_ready), 32'd1);
    chk("reset rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("reset rsp_rdata", m_rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(m_rsp_err), 32'd0);

    for (int i = 0; i < 20; i++) begin
      do_req(0, vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].err, $sformatf("vec%0d", i));
    end

    // Backpressure: response held 5 cycles; a request pulsed meanwhile is dropped.
    @(negedge clk);
    sel = 0; rsp_ready = 1'b0;
    req_wr = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 12'h020;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_rsp_valid && n < 40);
    chk("bp latency", n, 3);
    cap = m_rsp_rdata;
    chk("bp rdata", cap, 32'hAABB8001);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_wr = 1'b1; req_addr = 12'h020; req_wdata = 32'h0; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", i), 32'(m_rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_rdata", i), m_rsp_rdata, 32'hAABB8001);
      chk($sformatf("bp%0d rsp_err", i), 32'(m_rsp_err), 32'd0);
      chk($sformatf("bp%0d req_ready", i), 32'(m_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    do_req(0, 1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'hAABB8001, 1'b0, "bp after");

    // Zero wait states, back-to-back loads.
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 2'b10, 1'b0, 12'(4 * i), 32'hA0000000 + 32'(i), 32'h0, 1'b0,
             $sformatf("b2b st%0d", i));
    end
    sel = 1; rsp_ready = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d req_ready", i), 32'(m_req_ready), 32'd1);
      req_addr = 12'(4 * i);
      req_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("b2b%0d rsp_valid", i), 32'(m_rsp_valid), 32'd1);
      chk($sformatf("b2b%0d rdata", i), m_rsp_rdata, 32'hA0000000 + 32'(i));
      chk($sformatf("b2b%0d busy", i), 32'(m_req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;

    // Reset abort of a store still waiting.
    do_req(2, 1'b1, 2'b10, 1'b0, 12'h040, 32'h01020304, 32'h0, 1'b0, "ra st");
    do_req(2, 1'b0, 2'b10, 1'b0, 12'h040, 32'h0, 32'h01020304, 1'b0, "ra ld");
    @(negedge clk);
    sel = 2; req_wr = 1'b1; req_size = 2'b10; req_addr = 12'h040;
    req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("ra busy", 32'(m_req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ra req_ready", 32'(m_req_ready), 32'd1);
    chk("ra rsp_valid", 32'(m_rsp_valid), 32'd0);
    chk("ra rsp_rdata", m_rsp_rdata, 32'd0);
    chk("ra rsp_err", 32'(m_rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(2, 1'b0, 2'b10, 1'b0, 12'h040, 32'h0, 32'h01020304, 1'b0, "ra after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
